master_to_slave_mux: RTL and testbench

//  Forward (master->slave) path of the AHB interconnect. Routes the granted master's address/control in the

---
 rtl/master_to_slave_mux_pkg.sv | 42 ++++
 rtl/master_to_slave_mux_if.sv | 32 +++
 rtl/master_to_slave_mux_burst_tracker.sv | 86 ++++++++
 rtl/master_to_slave_mux.sv | 79 +++++++
 tb/tb_master_to_slave_mux.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/master_to_slave_mux_pkg.sv
// Shared AHB encodings, default sizing and burst-length decode for the forward mux.
package ahb_pkg;

    localparam int DEFAULT_NUM_MASTERS = 4;
    localparam int DEFAULT_ADDR_WIDTH  = 32;
    localparam int DEFAULT_DATA_WIDTH  = 32;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic {
        BT_IDLE  = 1'b0,
        BT_BURST = 1'b1
    } burst_state_e;

    // Beat count of a burst type; 0 stands for the unbounded INCR burst.
    function automatic logic [4:0] burst_len(hburst_e hburst);
        case (hburst)
            BURST_SINGLE:              burst_len = 5'd1;
            BURST_INCR:                burst_len = 5'd0;
            BURST_WRAP4, BURST_INCR4:  burst_len = 5'd4;
            BURST_WRAP8, BURST_INCR8:  burst_len = 5'd8;
            default:                   burst_len = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/master_to_slave_mux_if.sv
// Per-master request bundle plus the selected slave-side bus.
// master: the upstream side (masters and global HREADY source); slave: the mux itself.
interface master_to_slave_mux_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] Haddr_M  [NUM_MASTERS];
    logic [1:0]            Htrans_M [NUM_MASTERS];
    logic                  Hwrite_M [NUM_MASTERS];
    logic [2:0]            Hsize_M  [NUM_MASTERS];
    logic [2:0]            Hburst_M [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] Hwdata_M [NUM_MASTERS];
    logic                  Hready;

    logic [ADDR_WIDTH-1:0] Haddr;
    logic [1:0]            Htrans;
    logic                  Hwrite;
    logic [2:0]            Hsize;
    logic [2:0]            Hburst;
    logic [DATA_WIDTH-1:0] Hwdata;

    modport master (
        output Haddr_M, Htrans_M, Hwrite_M, Hsize_M, Hburst_M, Hwdata_M, Hready,
        input  Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata
    );

    modport slave (
        input  Haddr_M, Htrans_M, Hwrite_M, Hsize_M, Hburst_M, Hwdata_M, Hready,
        output Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata
    );
endinterface

// File: rtl/master_to_slave_mux_burst_tracker.sv
// Burst tracker: follows the selected master's burst and flags last beat, abandoned bursts and stray SEQs.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  BT_IDLE  | no burst open; a SEQ here is a protocol error
//  BT_BURST | burst open; beats_left>0 fixed-length, beats_left==0 INCR
module ahb_burst_tracker
    import ahb_pkg::*;
(
    input  logic         Hclk,
    input  logic         Hresetn,
    input  logic         hready,
    input  htrans_e      htrans,
    input  hburst_e      hburst,
    output logic         burst_last,
    output logic         burst_abort,
    output logic         seq_err
);
    burst_state_e state, state_nxt;
    logic [4:0]   beats_left, beats_nxt;
    logic [4:0]   len;
    logic         fixed_open;
    logic         abort_raw, seq_err_raw;

    // Tracker registers; frozen while HREADY is low.
    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            state      <= BT_IDLE;
            beats_left <= 5'd0;
        end else if (hready) begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
        end
    end

    // Next-state and per-cycle flags from the transfer type offered this cycle.
    always_comb begin
        state_nxt   = state;
        beats_nxt   = beats_left;
        burst_last  = 1'b0;
        abort_raw   = 1'b0;
        seq_err_raw = 1'b0;
        len         = burst_len(hburst);
        fixed_open  = (state == BT_BURST) && (beats_left != 5'd0);
        if (hready) begin
            case (htrans)
                TRANS_NONSEQ: begin
                    abort_raw  = fixed_open;
                    burst_last = (hburst == BURST_SINGLE);
                    if (len > 5'd1) begin
                        state_nxt = BT_BURST;
                        beats_nxt = len - 5'd1;
                    end else if (len == 5'd0) begin
                        state_nxt = BT_BURST;
                        beats_nxt = 5'd0;
                    end else begin
                        state_nxt = BT_IDLE;
                        beats_nxt = 5'd0;
                    end
                end
                TRANS_SEQ: begin
                    if (state == BT_IDLE) begin
                        seq_err_raw = 1'b1;
                    end else if (fixed_open) begin
                        beats_nxt  = beats_left - 5'd1;
                        burst_last = (beats_left == 5'd1);
                        if (beats_left == 5'd1) begin
                            state_nxt = BT_IDLE;
                        end
                    end
                end
                TRANS_IDLE: begin
                    abort_raw = fixed_open;
                    state_nxt = BT_IDLE;
                    beats_nxt = 5'd0;
                end
                default: ;
            endcase
        end
    end

    // Error pulses are forced low while reset is asserted.
    assign burst_abort = abort_raw & ~Hresetn;
    assign seq_err     = seq_err_raw & ~Hresetn;

endmodule

// File: rtl/master_to_slave_mux.sv
// Forward AHB path: address-phase select of the granted master, data-phase write-data select, burst tracking.
module master_to_slave_mux
    import ahb_pkg::*;
#(
    parameter  int NUM_MASTERS  = DEFAULT_NUM_MASTERS,
    parameter  int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    localparam int MASTER_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                    Hclk,
    input  logic                    Hresetn,
    input  logic [MASTER_WIDTH-1:0] Hmaster,
    master_to_slave_mux_if.slave    bus,
    output logic [MASTER_WIDTH-1:0] Hmaster_data,
    output logic                    data_active,
    output logic                    burst_last,
    output logic                    burst_abort,
    output logic                    seq_err
);
    htrans_e htrans_sel;
    logic    master_valid;
    logic    data_master_valid;
    logic    accept;
    logic    hwrite_d;

    // Address-phase select; an out-of-range grant presents an IDLE, all-zero request.
    always_comb begin
        master_valid = int'(Hmaster) < NUM_MASTERS;
        htrans_sel   = TRANS_IDLE;
        bus.Haddr    = '0;
        bus.Hwrite   = 1'b0;
        bus.Hsize    = 3'd0;
        bus.Hburst   = 3'd0;
        if (master_valid) begin
            htrans_sel = htrans_e'(bus.Htrans_M[Hmaster]);
            bus.Haddr  = bus.Haddr_M[Hmaster];
            bus.Hwrite = bus.Hwrite_M[Hmaster];
            bus.Hsize  = bus.Hsize_M[Hmaster];
            bus.Hburst = bus.Hburst_M[Hmaster];
        end
    end

    assign bus.Htrans = htrans_sel;
    assign accept     = bus.Hready & ((htrans_sel == TRANS_NONSEQ) | (htrans_sel == TRANS_SEQ));

    // Data-phase pipeline: remembers who owns the next data phase and whether it carries write data.
    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            Hmaster_data <= '0;
            data_active  <= 1'b0;
            hwrite_d     <= 1'b0;
        end else if (bus.Hready) begin
            Hmaster_data <= Hmaster;
            data_active  <= accept;
            hwrite_d     <= accept & bus.Hwrite;
        end
    end

    // Write data only flows during an active write data phase, so reads and idles see zero.
    always_comb begin
        data_master_valid = int'(Hmaster_data) < NUM_MASTERS;
        bus.Hwdata        = '0;
        if (data_active && hwrite_d && data_master_valid) begin
            bus.Hwdata = bus.Hwdata_M[Hmaster_data];
        end
    end

    ahb_burst_tracker u_burst_tracker (
        .Hclk        (Hclk),
        .Hresetn     (Hresetn),
        .hready      (bus.Hready),
        .htrans      (htrans_sel),
        .hburst      (hburst_e'(bus.Hburst)),
        .burst_last  (burst_last),
        .burst_abort (burst_abort),
        .seq_err     (seq_err)
    );

endmodule

// File: tb/tb_master_to_slave_mux.sv
// Directed bench for master_to_slave_mux: reset, address/data alignment, stalls, bursts, aborts, errors.
module tb_master_to_slave_mux;
    import ahb_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic       Hclk;
    logic       Hresetn;
    logic [1:0] Hmaster;
    logic [1:0] Hmaster_data;
    logic       data_active;
    logic       burst_last;
    logic       burst_abort;
    logic       seq_err;

    int n_checks = 0;
    int n_fail   = 0;

    master_to_slave_mux_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    master_to_slave_mux #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Hclk         (Hclk),
        .Hresetn      (Hresetn),
        .Hmaster      (Hmaster),
        .bus          (bus),
        .Hmaster_data (Hmaster_data),
        .data_active  (data_active),
        .burst_last   (burst_last),
        .burst_abort  (burst_abort),
        .seq_err      (seq_err)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Hclk);
        #1;
    endtask

    // One address-phase beat on master 0 with the expected tracker flags for that cycle.
    task automatic beat(input string tag, input htrans_e tr, input hburst_e bu,
                        input logic exp_last, input logic exp_abort, input logic exp_err);
        bus.Htrans_M[0] = tr;
        bus.Hburst_M[0] = bu;
        #1;
        chk({tag, ".burst_last"},  64'(burst_last),  64'(exp_last));
        chk({tag, ".burst_abort"}, 64'(burst_abort), 64'(exp_abort));
        chk({tag, ".seq_err"},     64'(seq_err),     64'(exp_err));
        next_cycle();
    endtask

    initial begin
        Hresetn    = 1'b1;
        bus.Hready = 1'b1;
        Hmaster    = 2'd0;
        for (int i = 0; i < NM; i++) begin
            bus.Htrans_M[i] = TRANS_IDLE;
            bus.Hwrite_M[i] = 1'b0;
            bus.Hsize_M[i]  = 3'd2;
            bus.Hburst_M[i] = BURST_SINGLE;
        end
        bus.Haddr_M[0]  = 32'h0000_0040;
        bus.Haddr_M[1]  = 32'h0000_0100;
        bus.Haddr_M[2]  = 32'h0000_0200;
        bus.Hwdata_M[0] = 32'h1111_1111;
        bus.Hwdata_M[1] = 32'h2222_2222;
        bus.Hwdata_M[2] = 32'h3333_3333;
        bus.Htrans_M[0] = TRANS_NONSEQ;
        bus.Hwrite_M[0] = 1'b1;

        // reset held with a live NONSEQ on master 0
        repeat (2) next_cycle();
        chk("rst.Hwdata",       64'(bus.Hwdata),  64'h0);
        chk("rst.data_active",  64'(data_active), 64'h0);
        chk("rst.Hmaster_data", 64'(Hmaster_data), 64'h0);
        chk("rst.Haddr",        64'(bus.Haddr),   64'h40);
        bus.Htrans_M[0] = TRANS_SEQ;
        #1;
        chk("rst.seq_err", 64'(seq_err), 64'h0);
        bus.Htrans_M[0] = TRANS_IDLE;
        bus.Hwrite_M[0] = 1'b0;
        Hresetn = 1'b0;
        #1;
        chk("rel.Haddr",  64'(bus.Haddr),  64'h40);
        chk("rel.Htrans", 64'(bus.Htrans), 64'(TRANS_IDLE));
        next_cycle();

        // master 1 single write, data one cycle behind address
        Hmaster = 2'd1;
        bus.Htrans_M[1] = TRANS_NONSEQ;
        bus.Hwrite_M[1] = 1'b1;
        #1;
        chk("wr.Haddr",      64'(bus.Haddr),  64'h100);
        chk("wr.Htrans",     64'(bus.Htrans), 64'(TRANS_NONSEQ));
        chk("wr.Hwrite",     64'(bus.Hwrite), 64'h1);
        chk("wr.burst_last", 64'(burst_last), 64'h1);
        next_cycle();
        Hmaster = 2'd0;
        bus.Htrans_M[1] = TRANS_IDLE;
        bus.Hwdata_M[1] = 32'hCAFE_F00D;
        #1;
        chk("wr.Hwdata",       64'(bus.Hwdata),  64'hCAFE_F00D);
        chk("wr.Hmaster_data", 64'(Hmaster_data), 64'h1);
        chk("wr.data_active",  64'(data_active), 64'h1);
        next_cycle();
        chk("wr.Hwdata_after", 64'(bus.Hwdata),  64'h0);

        // same write with a two-cycle stall in the data phase
        Hmaster = 2'd1;
        bus.Haddr_M[1]  = 32'h0000_0104;
        bus.Htrans_M[1] = TRANS_NONSEQ;
        next_cycle();
        Hmaster = 2'd2;
        bus.Htrans_M[1] = TRANS_IDLE;
        bus.Hwdata_M[1] = 32'hDEAD_BEEF;
        bus.Hready = 1'b0;
        #1;
        chk("stall.Hwdata0", 64'(bus.Hwdata), 64'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            chk("stall.Hwdata",       64'(bus.Hwdata),  64'hDEAD_BEEF);
            chk("stall.Hmaster_data", 64'(Hmaster_data), 64'h1);
            chk("stall.data_active",  64'(data_active), 64'h1);
        end
        bus.Hready = 1'b1;
        Hmaster = 2'd0;
        next_cycle();
        chk("stall.Hwdata_end",       64'(bus.Hwdata),  64'h0);
        chk("stall.Hmaster_data_end", 64'(Hmaster_data), 64'h0);

        // read on master 2: data phase active but no write data forwarded
        Hmaster = 2'd2;
        bus.Htrans_M[2] = TRANS_NONSEQ;
        next_cycle();
        Hmaster = 2'd0;
        bus.Htrans_M[2] = TRANS_IDLE;
        #1;
        chk("rd.Hmaster_data", 64'(Hmaster_data), 64'h2);
        chk("rd.data_active",  64'(data_active), 64'h1);
        chk("rd.Hwdata",       64'(bus.Hwdata),  64'h0);
        next_cycle();

        // out-of-range grant shows an idle, zeroed request
        Hmaster = 2'd3;
        bus.Htrans_M[2] = TRANS_NONSEQ;
        #1;
        chk("bad.Htrans", 64'(bus.Htrans), 64'(TRANS_IDLE));
        chk("bad.Haddr",  64'(bus.Haddr),  64'h0);
        next_cycle();
        chk("bad.data_active", 64'(data_active), 64'h0);
        bus.Htrans_M[2] = TRANS_IDLE;
        Hmaster = 2'd0;

        // INCR4 complete
        beat("i4.b1", TRANS_NONSEQ, BURST_INCR4, 1'b0, 1'b0, 1'b0);
        chk("i4.beats1", 64'(dut.u_burst_tracker.beats_left), 64'd3);
        beat("i4.b2", TRANS_SEQ, BURST_INCR4, 1'b0, 1'b0, 1'b0);
        beat("i4.b3", TRANS_SEQ, BURST_INCR4, 1'b0, 1'b0, 1'b0);
        beat("i4.b4", TRANS_SEQ, BURST_INCR4, 1'b1, 1'b0, 1'b0);
        chk("i4.state", 64'(dut.u_burst_tracker.state), 64'(BT_IDLE));
        chk("i4.beats", 64'(dut.u_burst_tracker.beats_left), 64'd0);
        beat("i4.idle", TRANS_IDLE, BURST_INCR4, 1'b0, 1'b0, 1'b0);

        // INCR8 abandoned after 3 beats by a new INCR4
        beat("i8.b1", TRANS_NONSEQ, BURST_INCR8, 1'b0, 1'b0, 1'b0);
        beat("i8.b2", TRANS_SEQ,    BURST_INCR8, 1'b0, 1'b0, 1'b0);
        beat("i8.b3", TRANS_SEQ,    BURST_INCR8, 1'b0, 1'b0, 1'b0);
        chk("i8.beats", 64'(dut.u_burst_tracker.beats_left), 64'd5);
        beat("i8.new", TRANS_NONSEQ, BURST_INCR4, 1'b0, 1'b1, 1'b0);
        chk("i8.reload_beats", 64'(dut.u_burst_tracker.beats_left), 64'd3);
        chk("i8.reload_state", 64'(dut.u_burst_tracker.state), 64'(BT_BURST));
        beat("i8.n2", TRANS_SEQ, BURST_INCR4, 1'b0, 1'b0, 1'b0);
        beat("i8.n3", TRANS_SEQ, BURST_INCR4, 1'b0, 1'b0, 1'b0);
        beat("i8.n4", TRANS_SEQ, BURST_INCR4, 1'b1, 1'b0, 1'b0);
        beat("i8.idle", TRANS_IDLE, BURST_INCR4, 1'b0, 1'b0, 1'b0);

        // BUSY holds the count; IDLE with beats pending aborts
        beat("busy.b1", TRANS_NONSEQ, BURST_WRAP4, 1'b0, 1'b0, 1'b0);
        beat("busy.busy", TRANS_BUSY, BURST_WRAP4, 1'b0, 1'b0, 1'b0);
        chk("busy.beats", 64'(dut.u_burst_tracker.beats_left), 64'd3);
        beat("busy.idle", TRANS_IDLE, BURST_WRAP4, 1'b0, 1'b1, 1'b0);
        chk("busy.state", 64'(dut.u_burst_tracker.state), 64'(BT_IDLE));

        // SEQ with no burst open
        beat("serr.seq",  TRANS_SEQ,  BURST_SINGLE, 1'b0, 1'b0, 1'b1);
        beat("serr.idle", TRANS_IDLE, BURST_SINGLE, 1'b0, 1'b0, 1'b0);

        // unbounded INCR ended by IDLE without abort
        beat("incr.b1", TRANS_NONSEQ, BURST_INCR, 1'b0, 1'b0, 1'b0);
        chk("incr.state", 64'(dut.u_burst_tracker.state), 64'(BT_BURST));
        beat("incr.b2", TRANS_SEQ, BURST_INCR, 1'b0, 1'b0, 1'b0);
        beat("incr.b3", TRANS_SEQ, BURST_INCR, 1'b0, 1'b0, 1'b0);
        beat("incr.idle", TRANS_IDLE, BURST_INCR, 1'b0, 1'b0, 1'b0);
        chk("incr.state_end", 64'(dut.u_burst_tracker.state), 64'(BT_IDLE));

        // reset asserted in the middle of an INCR16
        beat("i16.b1", TRANS_NONSEQ, BURST_INCR16, 1'b0, 1'b0, 1'b0);
        beat("i16.b2", TRANS_SEQ,    BURST_INCR16, 1'b0, 1'b0, 1'b0);
        beat("i16.b3", TRANS_SEQ,    BURST_INCR16, 1'b0, 1'b0, 1'b0);
        chk("i16.beats", 64'(dut.u_burst_tracker.beats_left), 64'd13);
        chk("i16.data_active", 64'(data_active), 64'h1);
        Hresetn = 1'b1;
        #1;
        chk("i16.rst_beats",       64'(dut.u_burst_tracker.beats_left), 64'd0);
        chk("i16.rst_state",       64'(dut.u_burst_tracker.state), 64'(BT_IDLE));
        chk("i16.rst_data_active", 64'(data_active), 64'h0);
        chk("i16.rst_seq_err",     64'(seq_err), 64'h0);
        bus.Htrans_M[0] = TRANS_IDLE;
        next_cycle();
        Hresetn = 1'b0;
        repeat (2) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
